// File: rtl/enemy_spawn_ctrl.sv
// Enemy spawn controller: owns game state, slot enables, lives, kills
// and the speed level fed to the y-coordinate stage.
module enemy_spawn_ctrl #(
    parameter logic [23:0] SPAWN_INTERVAL = 24'd12500000,
    parameter int          LEVEL_KILLS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] hit,
    input  logic [9:0] touch_edge,
    output logic [9:0] c_en,
    output logic [9:0] des,
    output logic       move_en,
    output logic [1:0] flying_rate,
    output logic [1:0] lives,
    output logic [7:0] kills,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t      state, state_n;
    logic [9:0]  c_en_n, des_n;
    logic [1:0]  lives_n, rate_n;
    logic [7:0]  kills_n;
    logic [3:0]  ptr, ptr_n;
    logic [23:0] timer, timer_n;

    logic [9:0]  hit_v, edge_v;
    logic [3:0]  hit_cnt, edge_cnt;
    logic [8:0]  kill_sum;
    logic [4:0]  slot;

    function automatic logic [3:0] pop10(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Lowest rotation distance from the pointer wins: scan far-to-near.
    function automatic logic [4:0] find_slot(input logic [9:0] used,
                                             input logic [3:0] from);
        logic [4:0] r;
        int idx;
        r = '0;
        for (int k = 9; k >= 0; k--) begin
            idx = (int'(from) + k) % 10;
            if (!used[idx]) r = {1'b1, 4'(idx)};
        end
        return r;
    endfunction

    assign hit_v    = hit & c_en;
    assign edge_v   = touch_edge & c_en & ~hit;
    assign hit_cnt  = pop10(hit_v);
    assign edge_cnt = pop10(edge_v);
    assign kill_sum = {1'b0, kills} + {5'b00000, hit_cnt};
    assign slot     = find_slot(c_en, ptr);

    assign move_en   = (state == RUN);
    assign game_over = (state == OVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            c_en        <= '0;
            des         <= '0;
            flying_rate <= 2'b01;
            lives       <= 2'd3;
            kills       <= '0;
            ptr         <= '0;
            timer       <= SPAWN_INTERVAL - 24'd1;
        end else begin
            state       <= state_n;
            c_en        <= c_en_n;
            des         <= des_n;
            flying_rate <= rate_n;
            lives       <= lives_n;
            kills       <= kills_n;
            ptr         <= ptr_n;
            timer       <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        c_en_n  = c_en;
        des_n   = '0;
        lives_n = lives;
        kills_n = kills;
        ptr_n   = ptr;
        timer_n = timer;
        if (int'(kills) < LEVEL_KILLS)          rate_n = 2'b01;
        else if (int'(kills) < 2 * LEVEL_KILLS) rate_n = 2'b10;
        else                                    rate_n = 2'b11;

        unique case (state)
            IDLE, OVER: begin
                c_en_n = '0;
                if (start) begin
                    state_n = RUN;
                    lives_n = 2'd3;
                    kills_n = '0;
                    ptr_n   = '0;
                    timer_n = SPAWN_INTERVAL - 24'd1;
                end
            end
            RUN: begin
                c_en_n  = c_en & ~(hit_v | edge_v);
                des_n   = hit_v | edge_v;
                kills_n = kill_sum[8] ? 8'hff : kill_sum[7:0];
                if ({2'b00, lives} <= edge_cnt) lives_n = 2'd0;
                else lives_n = lives - edge_cnt[1:0];

                if (lives_n == 2'd0) begin
                    // Game ends: flush every slot active this cycle.
                    state_n = OVER;
                    c_en_n  = '0;
                    des_n   = c_en;
                end else if (timer == 24'd0) begin
                    timer_n = SPAWN_INTERVAL - 24'd1;
                    if (slot[4]) begin
                        c_en_n[slot[3:0]] = 1'b1;
                        ptr_n = (slot[3:0] == 4'd9) ? 4'd0
                                                    : slot[3:0] + 4'd1;
                    end
                end else begin
                    timer_n = timer - 24'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Directed bench for enemy_spawn_ctrl with SPAWN_INTERVAL=4, LEVEL_KILLS=2.
module tb_enemy_spawn_ctrl;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [9:0] hit, touch_edge, c_en, des;
    logic       move_en, game_over;
    logic [1:0] flying_rate, lives;
    logic [7:0] kills;

    int total = 0;
    int bad   = 0;

    enemy_spawn_ctrl #(.SPAWN_INTERVAL(24'd4), .LEVEL_KILLS(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .hit(hit),
        .touch_edge(touch_edge),
        .c_en(c_en),
        .des(des),
        .move_en(move_en),
        .flying_rate(flying_rate),
        .lives(lives),
        .kills(kills),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_c_en"}, 32'(c_en), 32'h000);
        chk({tag, "_des"}, 32'(des), 32'h000);
        chk({tag, "_move"}, 32'(move_en), 32'd0);
        chk({tag, "_rate"}, 32'(flying_rate), 32'd1);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_kills"}, 32'(kills), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hit = '0;
        touch_edge = '0;
        step(2);
        chk_reset_state("rst");

        // c0: start; held high through RUN to show it is ignored there
        reset = 1'b0;
        start = 1'b1;
        step(1);
        chk("c1_move", 32'(move_en), 32'd1);
        chk("c1_c_en", 32'(c_en), 32'h000);
        step(3);
        chk("c4_c_en", 32'(c_en), 32'h000);
        step(1);
        chk("c5_c_en", 32'(c_en), 32'h001);
        step(4);
        chk("c9_c_en", 32'(c_en), 32'h003);
        step(4);
        chk("c13_c_en", 32'(c_en), 32'h007);

        // hit slot 1
        hit = 10'h002;
        step(1);
        hit = '0;
        chk("c14_c_en", 32'(c_en), 32'h005);
        chk("c14_des", 32'(des), 32'h002);
        chk("c14_kills", 32'(kills), 32'd1);
        step(1);
        chk("c15_des", 32'(des), 32'h000);
        chk("c15_rate", 32'(flying_rate), 32'd1);
        step(2);
        chk("c17_slot3", 32'(c_en), 32'h00d);

        // kills 1->2: rate follows one cycle later
        hit = 10'h001;
        step(1);
        hit = '0;
        chk("c18_kills", 32'(kills), 32'd2);
        chk("c18_rate", 32'(flying_rate), 32'd1);
        step(1);
        chk("c19_rate", 32'(flying_rate), 32'd2);
        hit = 10'h00c;
        start = 1'b0;
        step(1);
        hit = '0;
        chk("c20_kills", 32'(kills), 32'd4);
        chk("c20_c_en", 32'(c_en), 32'h000);
        step(1);
        chk("c21_rate", 32'(flying_rate), 32'd3);
        chk("c21_c_en", 32'(c_en), 32'h010);

        // lose two lives on bottom edge
        touch_edge = 10'h010;
        step(1);
        touch_edge = '0;
        chk("c22_lives", 32'(lives), 32'd2);
        chk("c22_des", 32'(des), 32'h010);
        step(3);
        chk("c25_c_en", 32'(c_en), 32'h020);
        touch_edge = 10'h020;
        step(1);
        touch_edge = '0;
        chk("c26_lives", 32'(lives), 32'd1);
        step(7);
        chk("c33_c_en", 32'(c_en), 32'h0c0);

        // hit and edge together on slot 7: a kill only
        hit = 10'h080;
        touch_edge = 10'h080;
        step(1);
        hit = '0;
        touch_edge = '0;
        chk("c34_lives", 32'(lives), 32'd1);
        chk("c34_kills", 32'(kills), 32'd5);
        chk("c34_c_en", 32'(c_en), 32'h040);
        chk("c34_des", 32'(des), 32'h080);

        // last life lost on slot 6
        touch_edge = 10'h040;
        step(1);
        touch_edge = '0;
        chk("c35_lives", 32'(lives), 32'd0);
        chk("c35_over", 32'(game_over), 32'd1);
        chk("c35_move", 32'(move_en), 32'd0);
        chk("c35_c_en", 32'(c_en), 32'h000);
        chk("c35_des", 32'(des), 32'h040);

        // inputs are ignored in OVER
        hit = 10'h3ff;
        touch_edge = 10'h3ff;
        step(1);
        hit = '0;
        touch_edge = '0;
        chk("c36_des", 32'(des), 32'h000);
        chk("c36_kills", 32'(kills), 32'd5);
        chk("c36_lives", 32'(lives), 32'd0);
        chk("c36_over", 32'(game_over), 32'd1);

        // restart from OVER
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("c37_lives", 32'(lives), 32'd3);
        chk("c37_kills", 32'(kills), 32'd0);
        chk("c37_over", 32'(game_over), 32'd0);
        chk("c37_move", 32'(move_en), 32'd1);
        step(1);
        chk("c38_rate", 32'(flying_rate), 32'd1);

        // fill all ten slots: slot 9 lands at c77
        step(39);
        chk("c77_full", 32'(c_en), 32'h3ff);
        step(4);
        chk("c81_full", 32'(c_en), 32'h3ff);
        chk("c81_des", 32'(des), 32'h000);

        // free slots 0 and 5; pointer still 0 so slot 0 refills first
        hit = 10'h021;
        step(1);
        hit = '0;
        chk("c82_c_en", 32'(c_en), 32'h3de);
        chk("c82_kills", 32'(kills), 32'd2);
        step(3);
        chk("c85_ptr", 32'(c_en), 32'h3df);

        // reset mid-RUN
        reset = 1'b1;
        hit = 10'h3ff;
        start = 1'b1;
        step(1);
        chk_reset_state("mid");
        reset = 1'b0;
        hit = '0;
        start = 1'b0;
        step(2);
        chk("idle_move", 32'(move_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
